sipo_rx_ctrl: RTL and testbench
===============================

Name: sipo_rx_ctrl

Overview:
Framing controller that sequences serial-in/parallel-out capture of a WIDTH-bit word. It sits between a bit-level source (bit + qualifier) and a word-level consumer with a valid/ready handshake. It owns an internal shift register, a bit counter, an inter-bit gap timeout and a one-word output buffer, and reports overrun and framing errors.

Parameters:
WIDTH, 8, data bits per frame (2..32)
MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1]; 0 = first bit lands in word_out[0]
GAP_MAX, 15, max idle cycles between accepted bits inside a frame before abort (1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse, begins a new frame
bit_valid  input  1  serial_in is valid this cycle
serial_in  input  1  serial data bit
word_out  output  WIDTH  assembled word (output buffer)
word_valid  output  1  word_out holds an unconsumed word
word_ready  input  1  consumer accepts word_out when word_valid & word_ready
busy  output  1  frame in progress (state SHIFT)
overrun  output  1  sticky: a completed word was dropped because the buffer was full
clr_overrun  input  1  clears overrun
frame_err  output  1  one-cycle pulse on gap-timeout abort
parity_err  output  1  one-cycle pulse on parity mismatch (PARITY_EN only)

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n), and all state is in the clk domain.
- Reset values: state=IDLE, shift reg=0, bit_cnt=0, gap_cnt=0, word_out=0, word_valid=0, busy=0, overrun=0, frame_err=0, parity_err=0.
- States:
  - IDLE: busy=0. bit_valid is ignored. start=1 -> SHIFT with bit_cnt=0 and gap_cnt=0. A bit presented in the same cycle as start is NOT sampled.
  - SHIFT: busy=1.
    - On bit_valid=1: shift in serial_in and bit_cnt++.
      - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], serial_in}.
      - MSB_FIRST=0: sreg <= {serial_in, sreg[WIDTH-1:1]}.
    - On bit_valid=0: gap_cnt++. Any accepted bit resets gap_cnt to 0.
    - Timeout: if gap_cnt reaches GAP_MAX with bit_valid=0 -> frame_err pulses on the next cycle, partial word is discarded, go to IDLE.
    - Last bit: when the frame's last bit is accepted (bit_cnt==WIDTH-1), complete the frame and go to IDLE on that edge.
- Frame completion, on the same edge that accepts the last bit:
  - If word_valid==0, or word_valid & word_ready this cycle: word_out <= assembled word and word_valid=1 from the next cycle. Latency is 1 cycle from the last bit to word_valid.
  - Otherwise the new word is dropped, word_out is unchanged, and overrun is set.
- Handshake:
  - word_valid stays high until word_valid & word_ready.
  - word_out is stable while word_valid=1.
  - A simultaneous drain and load keeps word_valid=1 with the new data.
- start while in SHIFT: restarts the frame. bit_cnt=0, gap_cnt=0, partial word discarded, no error flag. A bit in that same cycle is not sampled.
- start on the same edge as last-bit completion: the frame completes normally and the state goes to IDLE. start is ignored; only IDLE or mid-frame starts count.
- overrun: clr_overrun clears it. If set and clear occur in the same cycle, set wins.
- Reset mid-frame: immediate return to reset values, with no word or error emitted.

Optional Feature:
PARITY_EN
- Defined: each frame has WIDTH+1 bits. The final bit is even parity over the data bits and is not stored.
  - Match: complete the frame as above.
  - Mismatch: drop the word (no overrun), pulse parity_err for 1 cycle, go to IDLE.
- Undefined: frames are WIDTH bits and parity_err is tied to 0.

Test Plan:
- WIDTH=8, MSB_FIRST=1: start, then 8 consecutive bits 1,0,1,0,0,1,0,1 with word_ready=1 -> word_out=8'hA5 and word_valid high 1 cycle after the 8th bit, busy low on that cycle.
- MSB_FIRST=0, same bit sequence -> word_out=8'hA5 bit-reversed = 8'hA5 (palindromic check). Then send 1,1,0,0,0,0,0,0 -> word_out=8'h03.
- word_ready=0, two complete frames (8'h11 then 8'h22) -> word_out stays 8'h11 and overrun=1. Pulse clr_overrun -> overrun=0. Assert word_ready -> word_valid drops next cycle.
- start, 3 bits, then bit_valid low for GAP_MAX=15 cycles -> frame_err one-cycle pulse, busy=0, word_valid unchanged. start and 4 bits, then start again, then 8 bits of 8'h5A -> only 8'h5A is delivered.
- Reset asserted after bit 5 of a frame -> all outputs at reset values asynchronously. After release, a full frame of 8'hFF is delivered correctly.
- PARITY_EN: 8'hA5 with parity bit 0 -> delivered. 8'hA5 with parity bit 1 -> parity_err pulse, word_valid stays 0, overrun stays 0.

Source files
------------

// File: rtl/sipo_rx_ctrl.sv
// Serial-in/parallel-out framing controller with a one-word output buffer, gap timeout and overrun flag.
// Optional `define PARITY_EN appends an even-parity bit to every frame and enables parity_err.
module sipo_rx_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP_MAX   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             frame_err,
  output logic             parity_err
);

`ifdef PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [7:0]        GAP_LAST = 8'(GAP_MAX - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       gap_cnt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] assembled;
  logic             par_ok;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
    if (MSB_FIRST) return {s[WIDTH-2:0], b};
    else           return {b, s[WIDTH-1:1]};
  endfunction

  // With parity the last bit is the parity bit, so the word is already complete in sreg.
  always_comb begin
    shifted = shift_in(sreg, serial_in);
`ifdef PARITY_EN
    assembled = sreg;
    par_ok    = ((^sreg) == serial_in);
`else
    assembled = shifted;
    par_ok    = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (clr_overrun) overrun <= 1'b0;
      if (word_valid && word_ready) word_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            sreg    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end
        end
        SHIFT: begin
          // Completion outranks a coincident start; later assignments override the drain above.
          if (bit_valid && bit_cnt == LAST_BIT) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            if (!par_ok) begin
              parity_err <= 1'b1;
            end else if (!word_valid || word_ready) begin
              word_out   <= assembled;
              word_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else if (start) begin
            sreg    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end else if (bit_valid) begin
            sreg    <= shifted;
            bit_cnt <= bit_cnt + 1'b1;
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Bench for sipo_rx_ctrl: MSB-first and LSB-first instances share stimulus; a queue holds expected words.
module tb_sipo_rx_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, bit_valid = 1'b0, serial_in = 1'b0;
  logic word_ready = 1'b0, clr_overrun = 1'b0;
  logic [7:0] wo_m, wo_l;
  logic wv_m, wv_l, busy_m, busy_l, ov_m, ov_l, fe_m, fe_l, pe_m, pe_l;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_m_q[$];
  logic [7:0] exp_l_q[$];
  logic [7:0] em, el;

  always #5 clk = ~clk;

  sipo_rx_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .serial_in(serial_in),
    .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready), .busy(busy_m),
    .overrun(ov_m), .clr_overrun(clr_overrun), .frame_err(fe_m), .parity_err(pe_m));

  sipo_rx_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_MAX(15)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .serial_in(serial_in),
    .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready), .busy(busy_l),
    .overrun(ov_l), .clr_overrun(clr_overrun), .frame_err(fe_l), .parity_err(pe_l));

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp;
    if (exp_m_q.size() == 0 || exp_l_q.size() == 0) begin
      em = 8'hxx;
      el = 8'hxx;
    end else begin
      em = exp_m_q.pop_front();
      el = exp_l_q.pop_front();
    end
  endtask

  // w is given in transmission order: w[7] is sent first.
  task automatic send_frame(input logic [7:0] w, input bit push, input bit clr_last,
                            input bit start_last, input bit bad_par);
    int n;
`ifdef PARITY_EN
    n = 9;
`else
    n = 8;
`endif
    start = 1'b1; bit_valid = 1'b1; serial_in = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      serial_in = (i < 8) ? w[7-i] : ((^w) ^ bad_par);
      if (i == n - 1) begin
        clr_overrun = clr_last;
        start = start_last;
      end
      tick();
    end
    bit_valid = 1'b0; serial_in = 1'b0; clr_overrun = 1'b0; start = 1'b0;
    if (push) begin
      exp_m_q.push_back(w);
      exp_l_q.push_back(rev8(w));
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({wo_m, wv_m, busy_m, ov_m, fe_m, pe_m} !== 13'd0) begin
      errors++; $display("FAIL reset_msb: got %h required 0", {wo_m, wv_m, busy_m, ov_m, fe_m, pe_m});
    end
    checks++;
    if ({wo_l, wv_l, busy_l, ov_l, fe_l, pe_l} !== 13'd0) begin
      errors++; $display("FAIL reset_lsb: got %h required 0", {wo_l, wv_l, busy_l, ov_l, fe_l, pe_l});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_bit_order;
    word_ready = 1'b1;
    send_frame(8'hA5, 1, 0, 0, 0);
    pop_exp();
    checks++;
    if (wv_m !== 1'b1 || busy_m !== 1'b0) begin
      errors++; $display("FAIL a5_valid_busy: got valid=%b busy=%b required valid=1 busy=0", wv_m, busy_m);
    end
    checks++;
    if (wo_m !== em) begin errors++; $display("FAIL a5_msb: got %h required %h", wo_m, em); end
    checks++;
    if (wo_l !== el) begin errors++; $display("FAIL a5_lsb: got %h required %h", wo_l, el); end
    tick();
    checks++;
    if (wv_m !== 1'b0) begin errors++; $display("FAIL a5_drain: got valid=%b required 0", wv_m); end
    send_frame(8'hC0, 1, 0, 0, 0);
    pop_exp();
    checks++;
    if (wo_m !== em || wv_m !== 1'b1) begin
      errors++; $display("FAIL c0_msb: got %h valid=%b required %h valid=1", wo_m, wv_m, em);
    end
    checks++;
    if (wo_l !== el) begin errors++; $display("FAIL c0_lsb_03: got %h required %h", wo_l, el); end
    tick();
  endtask

  task automatic test_overrun;
    word_ready = 1'b0;
    send_frame(8'h11, 1, 0, 0, 0);
    send_frame(8'h22, 0, 0, 0, 0);
    pop_exp();
    checks++;
    if (wo_m !== em || wo_l !== el || wv_m !== 1'b1) begin
      errors++; $display("FAIL ovr_hold: got %h/%h valid=%b required %h/%h valid=1", wo_m, wo_l, wv_m, em, el);
    end
    checks++;
    if (ov_m !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b required 1", ov_m); end
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    checks++;
    if (ov_m !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b required 0", ov_m); end
    send_frame(8'h33, 0, 1, 0, 0);
    checks++;
    if (ov_m !== 1'b1 || wo_m !== em) begin
      errors++; $display("FAIL ovr_set_wins: got ovr=%b word=%h required ovr=1 word=%h", ov_m, wo_m, em);
    end
    clr_overrun = 1'b1; word_ready = 1'b1; tick(); clr_overrun = 1'b0;
    checks++;
    if (wv_m !== 1'b0 || ov_m !== 1'b0) begin
      errors++; $display("FAIL ovr_drain: got valid=%b ovr=%b required 0 0", wv_m, ov_m);
    end
  endtask

  task automatic test_gap_restart;
    word_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin bit_valid = 1'b1; serial_in = 1'b1; tick(); end
    bit_valid = 1'b0;
    repeat (14) tick();
    checks++;
    if (fe_m !== 1'b0 || busy_m !== 1'b1) begin
      errors++; $display("FAIL gap_early: got ferr=%b busy=%b required 0 1", fe_m, busy_m);
    end
    tick();
    checks++;
    if (fe_m !== 1'b1 || busy_m !== 1'b0 || wv_m !== 1'b0) begin
      errors++; $display("FAIL gap_abort: got ferr=%b busy=%b valid=%b required 1 0 0", fe_m, busy_m, wv_m);
    end
    tick();
    checks++;
    if (fe_m !== 1'b0) begin errors++; $display("FAIL gap_pulse: got ferr=%b required 0", fe_m); end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin bit_valid = 1'b1; serial_in = 1'b0; tick(); end
    send_frame(8'h5A, 1, 0, 0, 0);
    pop_exp();
    checks++;
    if (wo_m !== em || wo_l !== el || wv_m !== 1'b1 || fe_m !== 1'b0) begin
      errors++; $display("FAIL restart: got %h/%h valid=%b ferr=%b required %h/%h 1 0", wo_m, wo_l, wv_m, fe_m, em, el);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    word_ready = 1'b1;
    send_frame(8'h96, 1, 0, 1, 0);
    pop_exp();
    checks++;
    if (wo_m !== em || wv_m !== 1'b1 || busy_m !== 1'b0) begin
      errors++; $display("FAIL start_on_last: got %h valid=%b busy=%b required %h 1 0", wo_m, wv_m, busy_m, em);
    end
    for (int i = 0; i < 8; i++) begin bit_valid = 1'b1; serial_in = 1'b1; tick(); end
    bit_valid = 1'b0;
    checks++;
    if (wv_m !== 1'b0 || busy_m !== 1'b0) begin
      errors++; $display("FAIL idle_ignores_bits: got valid=%b busy=%b required 0 0", wv_m, busy_m);
    end
  endtask

  task automatic test_reset_mid;
    word_ready = 1'b0;
    send_frame(8'h3C, 1, 0, 0, 0);
    pop_exp();
    checks++;
    if (wo_m !== em || wv_m !== 1'b1) begin
      errors++; $display("FAIL pre_reset_word: got %h valid=%b required %h 1", wo_m, wv_m, em);
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin bit_valid = 1'b1; serial_in = 1'b1; tick(); end
    bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wo_m, wv_m, busy_m, ov_m, fe_m, pe_m} !== 13'd0) begin
      errors++; $display("FAIL async_reset: got %h required 0", {wo_m, wv_m, busy_m, ov_m, fe_m, pe_m});
    end
    tick();
    @(negedge clk) rst_n = 1'b1;
    word_ready = 1'b1;
    send_frame(8'hFF, 1, 0, 0, 0);
    pop_exp();
    checks++;
    if (wo_m !== em || wo_l !== el || wv_m !== 1'b1) begin
      errors++; $display("FAIL post_reset_ff: got %h/%h valid=%b required %h/%h 1", wo_m, wo_l, wv_m, em, el);
    end
    tick();
  endtask

`ifdef PARITY_EN
  task automatic test_parity;
    word_ready = 1'b1;
    send_frame(8'hA5, 1, 0, 0, 0);
    pop_exp();
    checks++;
    if (wo_m !== em || wv_m !== 1'b1 || pe_m !== 1'b0) begin
      errors++; $display("FAIL parity_good: got %h valid=%b perr=%b required %h 1 0", wo_m, wv_m, pe_m, em);
    end
    tick();
    send_frame(8'hA5, 0, 0, 0, 1);
    checks++;
    if (pe_m !== 1'b1 || wv_m !== 1'b0 || ov_m !== 1'b0) begin
      errors++; $display("FAIL parity_bad: got perr=%b valid=%b ovr=%b required 1 0 0", pe_m, wv_m, ov_m);
    end
    tick();
    checks++;
    if (pe_m !== 1'b0) begin errors++; $display("FAIL parity_pulse: got %b required 0", pe_m); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bit_order();
    test_overrun();
    test_gap_restart();
    test_back_to_back();
    test_reset_mid();
`ifdef PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_m_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left: got %0d pending required 0", exp_m_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
